// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and round-robin helper for the SPI master arbiter
package spi_pkg;
   localparam int MAX_REQ = 32;

   typedef enum logic [2:0] {IDLE, ARB, SETUP, START, WAIT, HOLD, GAP} state_t;

   // Scans downward so the requester closest after last ends up as the pick
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req, input int n, input int last);
      logic [MAX_REQ-1:0] sh;
      rr_pick = '0;
      for (int i = MAX_REQ; i > 0; i--)
         if (i <= n) begin
            sh = req >> ((last + i) % n);
            if (sh[0]) rr_pick = MAX_REQ'(1) << ((last + i) % n);
         end
   endfunction
endpackage

// File: rtl/spi_rr_picker.sv
// spi_rr_picker: one-hot round-robin pick starting just after the last owner
module spi_rr_picker
   import spi_pkg::*;
#(
   parameter int NUM_REQ = 4
)(
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last_owner,
   output logic [NUM_REQ-1:0]         pick,
   output logic                       valid
);
   assign pick  = NUM_REQ'(rr_pick(MAX_REQ'(req), NUM_REQ, int'(last_owner)));
   assign valid = |req;
endmodule

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one SPI byte master among NUM_REQ burst requesters
module spi_master_arbiter
   import spi_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int LEN_W     = 4,
   parameter int SETUP_CYC = 2,
   parameter int GAP_CYC   = 2
)(
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [NUM_REQ-1:0]       i_req,
   input  logic [NUM_REQ*LEN_W-1:0] i_len,
   input  logic [NUM_REQ*8-1:0]     i_tx_data,
   output logic [NUM_REQ-1:0]       o_grant,
   output logic [NUM_REQ-1:0]       o_tx_ack,
   output logic [7:0]               o_rx_data,
   output logic [NUM_REQ-1:0]       o_rx_valid,
   output logic [NUM_REQ-1:0]       o_burst_done,
   output logic                     o_m_start,
   output logic [7:0]               o_m_tx_byte,
   input  logic                     i_m_done,
   input  logic [7:0]               i_m_rx_byte,
   output logic [NUM_REQ-1:0]       o_ss_n
);
   localparam int OW = $clog2(NUM_REQ);
   localparam int TW = $clog2((SETUP_CYC > GAP_CYC ? SETUP_CYC : GAP_CYC) + 1);

   state_t             state, nxt;
   logic [OW-1:0]      owner, pick_idx;
   logic [LEN_W-1:0]   cnt;
   logic [TW-1:0]      tmr;
   logic [NUM_REQ-1:0] pick, own_oh;
   logic               valid, busy, rx_v, tmr_end;

   spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req(i_req),
      .last_owner(owner),
      .pick(pick),
      .valid(valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) if (pick[i]) pick_idx = OW'(i);
   end

   assign tmr_end = tmr == TW'((state == SETUP ? SETUP_CYC : GAP_CYC) - 1);

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    nxt = |i_req ? ARB : IDLE;
         ARB:     nxt = valid ? SETUP : IDLE;
         SETUP:   nxt = tmr_end ? START : SETUP;
         START:   nxt = WAIT;
         WAIT:    nxt = !i_m_done ? WAIT : cnt == '0 ? HOLD : START;
         HOLD:    nxt = GAP;
         GAP:     nxt = !tmr_end ? GAP : |i_req ? ARB : IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset)
      if (!i_reset) begin
         state     <= IDLE;
         owner     <= OW'(NUM_REQ - 1);
         cnt       <= '0;
         tmr       <= '0;
         rx_v      <= 1'b0;
         o_rx_data <= '0;
      end else begin
         state <= nxt;
         tmr   <= (nxt == state && (state == SETUP || state == GAP)) ? tmr + 1'b1 : '0;
         rx_v  <= state == WAIT && i_m_done;
         if (state == WAIT && i_m_done) begin
            o_rx_data <= i_m_rx_byte;
            if (cnt != '0) cnt <= cnt - 1'b1;
         end
         if (state == ARB && valid) begin
            owner <= pick_idx;
            cnt   <= LEN_W'(i_len >> (pick_idx * LEN_W));
         end
      end

   // Outputs decode from state so reset releases SS without waiting for a clock
   always_comb begin
      own_oh       = NUM_REQ'(1) << owner;
      busy         = state inside {SETUP, START, WAIT, HOLD};
      o_grant      = state == ARB ? pick : busy ? own_oh : '0;
      o_ss_n       = busy ? ~own_oh : '1;
      o_m_start    = state == START;
      o_tx_ack     = o_m_start ? own_oh : '0;
      o_m_tx_byte  = o_m_start ? 8'(i_tx_data >> {owner, 3'b000}) : 8'h00;
      o_rx_valid   = rx_v ? own_oh : '0;
      o_burst_done = state == HOLD ? own_oh : '0;
   end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed scenarios against a byte-master responder (rx = tx + 1, done 4 cycles after start)
module tb_spi_master_arbiter;
   localparam int NR = 4, LW = 4, SC = 2, GC = 2;

   logic             clk = 0, rst_n = 1;
   logic [NR-1:0]    req = '0;
   logic [NR*LW-1:0] len = '0;
   logic [NR*8-1:0]  txd = 32'h4D2B1A3C;
   logic             auto_done = 0, man_done = 0, m_done;
   logic [7:0]       rx_byte = 8'h00;
   logic [NR-1:0]    o_grant, o_tx_ack, o_rx_valid, o_burst_done, o_ss_n;
   logic [7:0]       o_rx_data, o_m_tx_byte;
   logic             o_m_start;

   int n_checks = 0, n_fail = 0;
   int n_start = 0, n_multi_ss = 0, n_bad_grant = 0, n_gap_viol = 0, hi_run = 0, seen_low = 0;
   int n_ack[NR], n_rxv[NR], n_done[NR], n_ss_low[NR];
   int glog[$];
   logic [NR-1:0] prev_grant = '0;
   logic [7:0]    last_tx = 8'h00, last_rx = 8'h00;

   always #5 clk = ~clk;
   assign m_done = auto_done | man_done;

   spi_master_arbiter #(.NUM_REQ(NR), .LEN_W(LW), .SETUP_CYC(SC), .GAP_CYC(GC)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_req(req), .i_len(len), .i_tx_data(txd),
      .o_grant(o_grant), .o_tx_ack(o_tx_ack), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
      .o_burst_done(o_burst_done), .o_m_start(o_m_start), .o_m_tx_byte(o_m_tx_byte),
      .i_m_done(m_done), .i_m_rx_byte(rx_byte), .o_ss_n(o_ss_n)
   );

   initial for (int k = 0; k < NR; k++) begin n_ack[k] = 0; n_rxv[k] = 0; n_done[k] = 0; n_ss_low[k] = 0; end

   always @(negedge clk) begin
      if (o_m_start) begin n_start++; last_tx = o_m_tx_byte; end
      if (o_rx_valid != '0) last_rx = o_rx_data;
      for (int k = 0; k < NR; k++) begin
         n_ack[k]    += int'(o_tx_ack[k]);
         n_rxv[k]    += int'(o_rx_valid[k]);
         n_done[k]   += int'(o_burst_done[k]);
         n_ss_low[k] += int'(!o_ss_n[k]);
      end
      if ($countones(~o_ss_n) > 1) n_multi_ss++;
      if (o_grant != '0 && !$onehot(o_grant)) n_bad_grant++;
      if (o_grant != '0 && prev_grant == '0)
         for (int k = 0; k < NR; k++) if (o_grant[k]) glog.push_back(k);
      prev_grant = o_grant;
      if (&o_ss_n) hi_run++;
      else begin
         if (hi_run > 0 && seen_low != 0 && hi_run < GC) n_gap_viol++;
         hi_run = 0;
         seen_low = 1;
      end
   end

   initial forever begin
      @(negedge clk);
      auto_done = 0;
      if (o_m_start) begin
         rx_byte = o_m_tx_byte + 8'h01;
         repeat (3) @(negedge clk);
         auto_done = 1;
      end
   end

   function automatic int done_total();
      int s = 0;
      for (int k = 0; k < NR; k++) s += n_done[k];
      return s;
   endfunction

   task automatic wait_grant(input int budget, output bit ok);
      int c = 0;
      while (o_grant == '0 && c < budget) begin @(negedge clk); c++; end
      ok = o_grant != '0;
   endtask

   task automatic wait_done(input int k, input int target, input int budget, output bit ok);
      int c = 0;
      while (n_done[k] < target && c < budget) begin @(negedge clk); c++; end
      ok = n_done[k] >= target;
   endtask

   task automatic test_reset();
      #3 rst_n = 0;
      #1;
      n_checks++; if (o_ss_n !== 4'hF) begin n_fail++; $display("FAIL reset_ss_n: got %h expected f", o_ss_n); end
      n_checks++; if (o_grant !== 4'h0) begin n_fail++; $display("FAIL reset_grant: got %h expected 0", o_grant); end
      n_checks++; if (o_m_start !== 1'b0) begin n_fail++; $display("FAIL reset_m_start: got %b expected 0", o_m_start); end
      n_checks++; if (o_m_tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h expected 00", o_m_tx_byte); end
      n_checks++; if (o_tx_ack !== 4'h0) begin n_fail++; $display("FAIL reset_tx_ack: got %h expected 0", o_tx_ack); end
      n_checks++; if (o_rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", o_rx_data); end
      n_checks++; if (o_rx_valid !== 4'h0) begin n_fail++; $display("FAIL reset_rx_valid: got %h expected 0", o_rx_valid); end
      n_checks++; if (o_burst_done !== 4'h0) begin n_fail++; $display("FAIL reset_burst_done: got %h expected 0", o_burst_done); end
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int base = glog.size(), d0 = done_total(), mss = n_multi_ss, gv = n_gap_viol, c = 0;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int got;
      len = '0;
      req = 4'hF;
      while (done_total() - d0 < 5 && c < 200) begin @(negedge clk); c++; end
      req = '0;
      n_checks++; if (done_total() - d0 !== 5) begin n_fail++; $display("FAIL rr_bursts: got %0d expected 5", done_total() - d0); end
      for (int i = 0; i < 5; i++) begin
         got = glog.size() > base + i ? glog[base + i] : -1;
         n_checks++; if (got !== exp_order[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got, exp_order[i]); end
      end
      n_checks++; if (n_gap_viol - gv !== 0) begin n_fail++; $display("FAIL rr_gap: got %0d short gaps expected 0", n_gap_viol - gv); end
      n_checks++; if (n_multi_ss - mss !== 0) begin n_fail++; $display("FAIL rr_ss_overlap: got %0d expected 0", n_multi_ss - mss); end
      repeat (4) @(negedge clk);
      n_checks++; if (o_grant !== 4'h0) begin n_fail++; $display("FAIL rr_idle_grant: got %h expected 0", o_grant); end
   endtask

   task automatic test_single();
      int s = n_start, a = n_ack[0], r = n_rxv[0], d = n_done[0], sl = n_ss_low[0];
      bit ok;
      len = 16'h0002;
      req = 4'h1;
      wait_grant(20, ok);
      n_checks++; if (o_grant !== 4'h1) begin n_fail++; $display("FAIL single_grant: got %h expected 1", o_grant); end
      @(negedge clk);
      req = '0;
      wait_done(0, d + 1, 100, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got no burst_done expected 1"); end
      repeat (4) @(negedge clk);
      n_checks++; if (n_start - s !== 3) begin n_fail++; $display("FAIL single_starts: got %0d expected 3", n_start - s); end
      n_checks++; if (n_ack[0] - a !== 3) begin n_fail++; $display("FAIL single_tx_ack: got %0d expected 3", n_ack[0] - a); end
      n_checks++; if (n_rxv[0] - r !== 3) begin n_fail++; $display("FAIL single_rx_valid: got %0d expected 3", n_rxv[0] - r); end
      n_checks++; if (n_done[0] - d !== 1) begin n_fail++; $display("FAIL single_done: got %0d expected 1", n_done[0] - d); end
      n_checks++; if (n_ss_low[0] - sl !== 15) begin n_fail++; $display("FAIL single_ss_low: got %0d cycles expected 15", n_ss_low[0] - sl); end
      n_checks++; if (last_tx !== 8'h3C) begin n_fail++; $display("FAIL single_tx_byte: got %h expected 3c", last_tx); end
      n_checks++; if (last_rx !== 8'h3D) begin n_fail++; $display("FAIL single_rx_data: got %h expected 3d", last_rx); end
   endtask

   task automatic test_lock();
      int s = n_start, a = n_ack[1], r = n_rxv[1], d = n_done[1], a0 = n_ack[0], c = 0;
      bit ok;
      len = 16'h0030;
      req = 4'h2;
      while (n_start == s && c < 30) begin @(negedge clk); c++; end
      req = '0;
      wait_done(1, d + 1, 100, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL lock_timeout: got no burst_done expected 1"); end
      repeat (4) @(negedge clk);
      n_checks++; if (n_start - s !== 4) begin n_fail++; $display("FAIL lock_starts: got %0d expected 4", n_start - s); end
      n_checks++; if (n_ack[1] - a !== 4) begin n_fail++; $display("FAIL lock_tx_ack: got %0d expected 4", n_ack[1] - a); end
      n_checks++; if (n_rxv[1] - r !== 4) begin n_fail++; $display("FAIL lock_rx_valid: got %0d expected 4", n_rxv[1] - r); end
      n_checks++; if (n_done[1] - d !== 1) begin n_fail++; $display("FAIL lock_done: got %0d expected 1", n_done[1] - d); end
      n_checks++; if (n_ack[0] - a0 !== 0) begin n_fail++; $display("FAIL lock_other_ack: got %0d expected 0", n_ack[0] - a0); end
      n_checks++; if (last_rx !== 8'h1B) begin n_fail++; $display("FAIL lock_rx_data: got %h expected 1b", last_rx); end
   endtask

   task automatic test_max_len();
      int s = n_start, r = n_rxv[2], d = n_done[2], sl = n_ss_low[2];
      bit ok;
      len = 16'h0F00;
      req = 4'h4;
      wait_grant(20, ok);
      @(negedge clk);
      req = '0;
      wait_done(2, d + 1, 300, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL max_timeout: got no burst_done expected 1"); end
      repeat (4) @(negedge clk);
      n_checks++; if (n_start - s !== 16) begin n_fail++; $display("FAIL max_starts: got %0d expected 16", n_start - s); end
      n_checks++; if (n_rxv[2] - r !== 16) begin n_fail++; $display("FAIL max_rx_valid: got %0d expected 16", n_rxv[2] - r); end
      n_checks++; if (n_done[2] - d !== 1) begin n_fail++; $display("FAIL max_done: got %0d expected 1", n_done[2] - d); end
      n_checks++; if (n_ss_low[2] - sl !== 67) begin n_fail++; $display("FAIL max_ss_low: got %0d cycles expected 67", n_ss_low[2] - sl); end
      n_checks++; if (last_rx !== 8'h2C) begin n_fail++; $display("FAIL max_rx_data: got %h expected 2c", last_rx); end
   endtask

   task automatic test_spurious_done();
      int r0 = n_rxv[0] + n_rxv[1] + n_rxv[2] + n_rxv[3], s, r, d;
      bit ok;
      man_done = 1;
      @(negedge clk);
      man_done = 0;
      repeat (2) @(negedge clk);
      n_checks++; if (n_rxv[0] + n_rxv[1] + n_rxv[2] + n_rxv[3] - r0 !== 0) begin n_fail++; $display("FAIL idle_done_rx_valid: got %0d expected 0", n_rxv[0] + n_rxv[1] + n_rxv[2] + n_rxv[3] - r0); end
      n_checks++; if (o_ss_n !== 4'hF || o_grant !== 4'h0) begin n_fail++; $display("FAIL idle_done_state: got ss_n %h grant %h expected f 0", o_ss_n, o_grant); end
      s = n_start; r = n_rxv[0]; d = n_done[0];
      len = '0;
      req = 4'h1;
      wait_grant(20, ok);
      @(negedge clk);
      req = '0;
      man_done = 1;
      @(negedge clk);
      man_done = 0;
      n_checks++; if (o_m_start !== 1'b0 || o_ss_n !== 4'hE) begin n_fail++; $display("FAIL setup_done_state: got start %b ss_n %h expected 0 e", o_m_start, o_ss_n); end
      @(negedge clk);
      n_checks++; if (o_m_start !== 1'b1) begin n_fail++; $display("FAIL setup_done_start: got %b expected 1", o_m_start); end
      wait_done(0, d + 1, 50, ok);
      repeat (4) @(negedge clk);
      n_checks++; if (n_rxv[0] - r !== 1 || n_start - s !== 1) begin n_fail++; $display("FAIL setup_done_bytes: got rx_valid %0d starts %0d expected 1 1", n_rxv[0] - r, n_start - s); end
   endtask

   task automatic test_reset_mid_wait();
      int d = n_done[1], c = 0;
      len = 16'h0030;
      req = 4'h2;
      while (!o_m_start && c < 30) begin @(negedge clk); c++; end
      req = '0;
      @(negedge clk);
      n_checks++; if (o_ss_n !== 4'hD) begin n_fail++; $display("FAIL midwait_ss_n: got %h expected d", o_ss_n); end
      #2 rst_n = 0;
      #1;
      n_checks++; if (o_ss_n !== 4'hF) begin n_fail++; $display("FAIL async_ss_release: got %h expected f", o_ss_n); end
      n_checks++; if (o_grant !== 4'h0 || o_m_start !== 1'b0) begin n_fail++; $display("FAIL async_idle: got grant %h start %b expected 0 0", o_grant, o_m_start); end
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (10) @(negedge clk);
      n_checks++; if (n_done[1] - d !== 0) begin n_fail++; $display("FAIL aborted_done: got %0d expected 0", n_done[1] - d); end
      n_checks++; if (o_rx_data !== 8'h00 || o_ss_n !== 4'hF) begin n_fail++; $display("FAIL after_reset: got rx %h ss_n %h expected 00 f", o_rx_data, o_ss_n); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_lock();
      test_max_len();
      test_spurious_done();
      test_reset_mid_wait();
      n_checks++; if (n_multi_ss !== 0) begin n_fail++; $display("FAIL ss_one_low: got %0d overlaps expected 0", n_multi_ss); end
      n_checks++; if (n_bad_grant !== 0) begin n_fail++; $display("FAIL grant_onehot: got %0d bad cycles expected 0", n_bad_grant); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 4, number of requesters; LEN_W, default 4, burst-length field width; SETUP_CYC, default 2, cycles from SS low to first start; GAP_CYC, default 2, minimum idle cycles between bursts.
REQ-002 SHALL have ports: i_clk  in  1  clock, rising edge; i_reset  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: i_req  in  NUM_REQ  level request per requester; i_len  in  NUM_REQ*LEN_W  burst length minus one, slice k belongs to requester k; i_tx_data  in  NUM_REQ*8  next TX byte, slice k.
REQ-004 SHALL have ports: o_grant  out  NUM_REQ  one-hot owner; o_tx_ack  out  NUM_REQ  1-cycle pulse, TX byte consumed; o_rx_data  out  8  last received byte; o_rx_valid  out  NUM_REQ  1-cycle pulse to owner; o_burst_done  out  NUM_REQ  1-cycle pulse at burst end.
REQ-005 SHALL have master-side ports: o_m_start  out  1  1-cycle start pulse; o_m_tx_byte  out  8  byte to shift; i_m_done  in  1  1-cycle byte-complete pulse; i_m_rx_byte  in  8  valid with i_m_done; o_ss_n  out  NUM_REQ  active-low chip selects.

Function
REQ-006 SHALL implement FSM states IDLE, ARB, SETUP, START, WAIT, HOLD, GAP.
REQ-007 IDLE -> ARB when any i_req bit is 1; else stay.
REQ-008 ARB SHALL grant round-robin: search begins at index last_owner+1 modulo NUM_REQ; after reset last_owner = NUM_REQ-1, so requester 0 has first priority; ARB lasts exactly 1 cycle, latches owner and i_len slice into byte counter, -> SETUP.
REQ-009 SETUP SHALL drive o_ss_n[owner]=0 for SETUP_CYC cycles, then -> START.
REQ-010 START SHALL, for exactly 1 cycle, assert o_m_start, drive o_m_tx_byte from the owner's i_tx_data slice and pulse o_tx_ack[owner], then -> WAIT.
REQ-011 WAIT SHALL hold until i_m_done; on i_m_done, register i_m_rx_byte into o_rx_data and pulse o_rx_valid[owner] the next cycle; if byte counter = 0 -> HOLD, else decrement and -> START.
REQ-012 HOLD SHALL last 1 cycle with SS still low, pulse o_burst_done[owner], then -> GAP with o_ss_n all 1.
REQ-013 GAP SHALL hold for GAP_CYC cycles, then -> ARB if any i_req, else IDLE.
REQ-014 Grant SHALL be locked for the whole burst; deassertion of i_req[owner] mid-burst SHALL NOT abort it.
REQ-015 o_grant SHALL be one-hot from ARB through HOLD and all zero in IDLE and GAP; at most one o_ss_n bit SHALL be low at any time.
REQ-016 i_len = 0 SHALL mean one byte; maximum burst = 2^LEN_W bytes; counter SHALL NOT wrap.
REQ-017 i_m_done outside WAIT SHALL be ignored.
REQ-018 A request arriving for the just-served requester SHALL lose to any other pending requester at the next ARB.

Reset
REQ-019 Asynchronous assertion SHALL force: state IDLE, o_ss_n all 1, o_grant 0, o_m_start 0, o_m_tx_byte 0, o_tx_ack 0, o_rx_data 0, o_rx_valid 0, o_burst_done 0, last_owner NUM_REQ-1, counters 0.
REQ-020 Reset mid-burst SHALL release SS immediately (not waiting for a clock edge); no o_burst_done pulse SHALL be produced for the aborted burst.

Structure
REQ-021 State encodings and a round-robin helper function SHALL reside in shared package spi_pkg.
REQ-022 Round-robin selection SHALL be a sub-module spi_rr_picker (inputs: request vector, last owner; output: one-hot pick, valid).

Verification
REQ-023 Single request: i_req=0001, i_len[0]=2, i_m_done 4 cycles after each start -> 3 o_m_start pulses, 3 o_tx_ack[0], 3 o_rx_valid[0], o_ss_n[0] low from ARB+1 through HOLD, one o_burst_done[0].
REQ-024 Round-robin: i_req=1111 held, all i_len=0 -> grant order 0,1,2,3,0; each SS low window disjoint, separated by at least GAP_CYC cycles.
REQ-025 Lock: i_req[1] drops after first start of a 4-byte burst -> all 4 bytes complete, o_burst_done[1] pulses.
REQ-026 Max length: i_len=4'hF -> exactly 16 bytes, counter does not wrap.
REQ-027 Reset mid-WAIT: i_reset low with o_ss_n=1101 -> o_ss_n=1111 asynchronously, FSM IDLE, no o_burst_done.
REQ-028 Spurious i_m_done in IDLE/SETUP -> no o_rx_valid, state unchanged.
